// File: rtl/nv_nvdla_mcif_wr_cpl_tracker.sv
// MCIF write completion tracker: per-client in-order context queues,
// outstanding-beat metering against reg2dp_wr_os_cnt, B-response routing
// and per-client completion pulses with sticky error flags.

// Per-client context queue. Pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate count.
module nv_nvdla_mcif_wr_cpl_tracker_cq #(
  parameter int DW    = 3,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [DW-1:0] mem [DEPTH];

  // Pointer update; reset discards every queued context.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module nv_nvdla_mcif_wr_cpl_tracker #(
  parameter int NUM_CLIENTS = 5,
  parameter int ID_W        = 8,
  parameter int LEN_W       = 2,
  parameter int CQ_DEPTH    = 8,
  parameter int OS_W        = 9
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   aw_issue_vld,
  output logic                   aw_issue_rdy,
  input  logic [ID_W-1:0]        aw_issue_id,
  input  logic [LEN_W-1:0]       aw_issue_len,
  input  logic                   aw_issue_ack_req,
  input  logic [7:0]             reg2dp_wr_os_cnt,
  input  logic                   b_vld,
  output logic                   b_rdy,
  input  logic [ID_W-1:0]        b_id,
  output logic [NUM_CLIENTS-1:0] wr_rsp_complete,
  output logic [OS_W-1:0]        os_beats,
  output logic                   err_bad_id,
  output logic                   err_underflow
);
  localparam int CL_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [OS_W:0]   ONE_X = 1;
  localparam logic [OS_W-1:0] ONE   = 1;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             ack_req;
  } cq_entry_t;

  logic [CL_W-1:0] cl, bc;
  logic            cl_ok, cl_full, bc_ok, bc_empty;
  cq_entry_t       bc_head, aw_entry;
  logic            aw_acc, b_hs, b_pop;
  logic [OS_W:0]   beats_need, beats_limit;
  logic [OS_W-1:0] issue_beats, rel_beats;

  logic      [NUM_CLIENTS-1:0] q_push, q_pop, q_full, q_empty, head_ack;
  cq_entry_t [NUM_CLIENTS-1:0] q_head;

  assign cl = aw_issue_id[CL_W-1:0];
  assign bc = b_id[CL_W-1:0];
  assign aw_entry = '{len: aw_issue_len, ack_req: aw_issue_ack_req};

  // Select per-client status for the issuing and responding client; ids
  // beyond NUM_CLIENTS match no client and leave *_ok low.
  always_comb begin
    cl_ok    = 1'b0;
    cl_full  = 1'b0;
    bc_ok    = 1'b0;
    bc_empty = 1'b1;
    bc_head  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (cl == CL_W'(i)) begin
        cl_ok   = 1'b1;
        cl_full = q_full[i];
      end
      if (bc == CL_W'(i)) begin
        bc_ok    = 1'b1;
        bc_empty = q_empty[i];
        bc_head  = q_head[i];
      end
    end
  end

  // One extra bit keeps the limit compare free of overflow.
  assign beats_need   = {1'b0, os_beats} + (OS_W+1)'(aw_issue_len) + ONE_X;
  assign beats_limit  = (OS_W+1)'(reg2dp_wr_os_cnt) + ONE_X;
  assign aw_issue_rdy = nvdla_core_rstn && cl_ok && !cl_full && (beats_need <= beats_limit);

  assign aw_acc = aw_issue_vld && aw_issue_rdy;
  assign b_hs   = b_vld && b_rdy;
  assign b_pop  = b_hs && bc_ok && !bc_empty;

  assign issue_beats = aw_acc ? (OS_W'(aw_issue_len) + ONE) : '0;
  assign rel_beats   = b_pop  ? (OS_W'(bc_head.len)  + ONE) : '0;

  genvar g;
  generate
    for (g = 0; g < NUM_CLIENTS; g++) begin : g_cq
      assign q_push[g]   = aw_acc && (cl == CL_W'(g));
      assign q_pop[g]    = b_pop  && (bc == CL_W'(g));
      assign head_ack[g] = q_head[g].ack_req;

      nv_nvdla_mcif_wr_cpl_tracker_cq #(
        .DW    (LEN_W + 1),
        .DEPTH (CQ_DEPTH)
      ) u_cq (
        .clk   (nvdla_core_clk),
        .rstn  (nvdla_core_rstn),
        .push  (q_push[g]),
        .din   (aw_entry),
        .pop   (q_pop[g]),
        .dout  (q_head[g]),
        .full  (q_full[g]),
        .empty (q_empty[g])
      );
    end
  endgenerate

  // Outstanding beats, completion pulses, B ready and sticky error flags.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      os_beats        <= '0;
      wr_rsp_complete <= '0;
      b_rdy           <= 1'b0;
      err_bad_id      <= 1'b0;
      err_underflow   <= 1'b0;
    end else begin
      os_beats        <= os_beats + issue_beats - rel_beats;
      wr_rsp_complete <= q_pop & head_ack;
      b_rdy           <= 1'b1;
      if (b_hs && !bc_ok)            err_bad_id    <= 1'b1;
      if (b_hs && bc_ok && bc_empty) err_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_nv_nvdla_mcif_wr_cpl_tracker.sv
// Bench for the write completion tracker: reset check, directed vector table,
// a queue-full corner sequence and a randomized run against a queue model.
module tb_nv_nvdla_mcif_wr_cpl_tracker;
  localparam int NC = 5;

  logic       clk = 1'b0;
  logic       rstn;
  logic       aw_vld, aw_rdy, aw_ack;
  logic [7:0] aw_id, os_cnt, b_id;
  logic [1:0] aw_len;
  logic       b_vld, b_rdy;
  logic [4:0] cpl;
  logic [8:0] os_beats;
  logic       err_bad, err_uf;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nv_nvdla_mcif_wr_cpl_tracker dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .aw_issue_vld     (aw_vld),
    .aw_issue_rdy     (aw_rdy),
    .aw_issue_id      (aw_id),
    .aw_issue_len     (aw_len),
    .aw_issue_ack_req (aw_ack),
    .reg2dp_wr_os_cnt (os_cnt),
    .b_vld            (b_vld),
    .b_rdy            (b_rdy),
    .b_id             (b_id),
    .wr_rsp_complete  (cpl),
    .os_beats         (os_beats),
    .err_bad_id       (err_bad),
    .err_underflow    (err_uf)
  );

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic drive(bit v, int id, int len, bit ack, int osc, bit bv, int bid);
    aw_vld = v; aw_id = 8'(id); aw_len = 2'(len); aw_ack = ack;
    os_cnt = 8'(osc); b_vld = bv; b_id = 8'(bid);
  endtask

  typedef struct {
    bit aw_vld; int id; int len; bit ack; int osc; bit b_vld; int bid;
    bit e_rdy; int e_os; int e_cpl; bit e_bad; bit e_uf;
  } vec_t;
  vec_t tbl[$];

  // Reference model: plain queues of contexts per client.
  int mq_len[NC][$];
  bit mq_ack[NC][$];
  int m_os, m_cpl;
  bit m_bad, m_uf, m_brdy;

  // One randomized-phase cycle: inputs already driven; predict, clock, compare.
  task automatic rcyc();
    int cl, bc, rel, ncpl, l;
    bit erdy, acc, bhs, a;
    cl = int'(aw_id[2:0]);
    bc = int'(b_id[2:0]);
    erdy = 1'b0;
    if (rstn && cl < NC)
      erdy = (mq_len[cl].size() < 8) && (m_os + int'(aw_len) + 1 <= int'(os_cnt) + 1);
    #1;
    chk("rnd_aw_rdy", aw_rdy, erdy);
    chk("rnd_b_rdy", b_rdy, m_brdy);
    if (!rstn) begin
      for (int i = 0; i < NC; i++) begin mq_len[i].delete(); mq_ack[i].delete(); end
      m_os = 0; m_cpl = 0; m_bad = 0; m_uf = 0; m_brdy = 0;
    end else begin
      acc = aw_vld && erdy;
      bhs = b_vld && m_brdy;
      rel = 0; ncpl = 0;
      if (bhs) begin
        if (bc >= NC) m_bad = 1;
        else if (mq_len[bc].size() == 0) m_uf = 1;
        else begin
          l = mq_len[bc].pop_front();
          a = mq_ack[bc].pop_front();
          rel = l + 1;
          if (a) ncpl = 1 << bc;
        end
      end
      if (acc) begin
        mq_len[cl].push_back(int'(aw_len));
        mq_ack[cl].push_back(aw_ack);
        m_os += int'(aw_len) + 1;
      end
      m_os -= rel;
      m_cpl = ncpl;
      m_brdy = 1;
    end
    @(posedge clk); #1;
    chk("rnd_os_beats", os_beats, m_os);
    chk("rnd_complete", cpl, m_cpl);
    chk("rnd_err_bad_id", err_bad, m_bad);
    chk("rnd_err_underflow", err_uf, m_uf);
  endtask

  initial begin
    rstn = 1'b0;
    drive(1, 0, 0, 1, 3, 1, 0);

    // Reset: B offered throughout, nothing may happen.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_b_rdy", b_rdy, 0);
      chk("rst_aw_rdy", aw_rdy, 0);
      chk("rst_os_beats", os_beats, 0);
      chk("rst_complete", cpl, 0);
      chk("rst_errs", {err_bad, err_uf}, 0);
    end
    @(negedge clk);
    rstn = 1'b1;
    drive(0, 0, 0, 0, 3, 0, 0);
    @(posedge clk); #1;
    chk("rel_b_rdy", b_rdy, 1);

    // Directed vectors: {aw vld,id,len,ack, os_cnt, b vld,id} -> {rdy, os, cpl, bad, uf}
    tbl.push_back(vec_t'{1, 0, 3, 1,   3, 0, 0,    1, 4, 0, 0, 0});
    tbl.push_back(vec_t'{1, 1, 0, 1,   3, 0, 0,    0, 4, 0, 0, 0});
    tbl.push_back(vec_t'{1, 1, 0, 1,   3, 1, 0,    0, 0, 1, 0, 0});
    tbl.push_back(vec_t'{1, 1, 0, 1,   3, 0, 0,    1, 1, 0, 0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0,   3, 1, 1,    1, 0, 2, 0, 0});
    tbl.push_back(vec_t'{1, 2, 1, 1,   3, 0, 0,    1, 2, 0, 0, 0});
    tbl.push_back(vec_t'{1, 2, 0, 0,   3, 0, 0,    1, 3, 0, 0, 0});
    tbl.push_back(vec_t'{0, 2, 0, 0,   3, 1, 2,    1, 1, 4, 0, 0});
    tbl.push_back(vec_t'{0, 2, 0, 0,   3, 1, 2,    1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 2, 0, 0,   3, 0, 0,    1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 2, 0, 0,   3, 1, 7,    1, 0, 0, 1, 0});
    tbl.push_back(vec_t'{0, 2, 0, 0,   3, 1, 0,    1, 0, 0, 1, 1});
    tbl.push_back(vec_t'{1, 0, 1, 0,   3, 0, 0,    1, 2, 0, 1, 1});
    tbl.push_back(vec_t'{1, 1, 2, 1,   7, 1, 0,    1, 3, 0, 1, 1});
    tbl.push_back(vec_t'{0, 1, 0, 0,   7, 1, 1,    1, 0, 2, 1, 1});
    tbl.push_back(vec_t'{1, 5, 0, 0, 255, 0, 0,    0, 0, 0, 1, 1});
    tbl.push_back(vec_t'{1, 9, 0, 0, 255, 0, 0,    1, 1, 0, 1, 1});
    tbl.push_back(vec_t'{0, 9, 0, 0, 255, 1, 17,   1, 0, 0, 1, 1});
    tbl.push_back(vec_t'{1, 0, 3, 0,   0, 0, 0,    0, 0, 0, 1, 1});

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].aw_vld, tbl[k].id, tbl[k].len, tbl[k].ack, tbl[k].osc, tbl[k].b_vld, tbl[k].bid);
      #1;
      chk($sformatf("vec%0d_aw_rdy", k), aw_rdy, tbl[k].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_os_beats", k), os_beats, tbl[k].e_os);
      chk($sformatf("vec%0d_complete", k), cpl, tbl[k].e_cpl);
      chk($sformatf("vec%0d_err_bad_id", k), err_bad, tbl[k].e_bad);
      chk($sformatf("vec%0d_err_underflow", k), err_uf, tbl[k].e_uf);
    end

    // Fill client 4, then pop and push it in the same cycle: push still blocked.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(1, 4, 0, 0, 255, 0, 0);
    end
    @(negedge clk); drive(0, 4, 0, 0, 255, 0, 0); #1;
    chk("full_os_beats", os_beats, 8);
    chk("full_rdy_id4", aw_rdy, 0);
    aw_id = 8'd3; #1;
    chk("full_rdy_id3", aw_rdy, 1);
    @(negedge clk); drive(1, 4, 0, 0, 255, 1, 4); #1;
    chk("full_pop_push_rdy", aw_rdy, 0);
    @(posedge clk); #1;
    chk("full_pop_os", os_beats, 7);
    @(negedge clk); drive(1, 4, 0, 0, 255, 0, 0); #1;
    chk("full_next_rdy", aw_rdy, 1);
    @(posedge clk); #1;
    chk("full_next_os", os_beats, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(0, 4, 0, 0, 255, 1, 4);
    end
    @(negedge clk); drive(0, 0, 0, 0, 255, 0, 0); #1;
    chk("drain_os", os_beats, 0);

    // Randomized phase with model; starts and reenters reset mid-run.
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rcyc();
    end
    m_brdy = 0;
    os_cnt = 8'd6;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rstn   = !(c >= 800 && c < 802);
      aw_vld = ($urandom_range(0, 9) < 6);
      aw_id  = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(5, 255)) : 8'($urandom_range(0, 4));
      aw_len = 2'($urandom);
      aw_ack = 1'($urandom);
      if ($urandom_range(0, 49) == 0)
        os_cnt = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
      b_vld  = ($urandom_range(0, 9) < 4);
      b_id   = ($urandom_range(0, 31) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      rcyc();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
